cache_ctrl_wt: RTL and testbench

//  Sequencing FSM for the 32-line, 4-word direct-mapped write-through data cache (no-write-allocate).

---
 rtl/cache_ctrl_wt.sv | 195 +++++++++++++++++++
 tb/tb_cache_ctrl_wt.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_wt.sv
// Sequencing FSM for a 32-line, 4-word direct-mapped write-through data cache (no-write-allocate).
// Owns the tag/valid array, stalls the CPU on misses and stores, and handshakes with main memory.
module cache_ctrl_wt #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic [4:0]        cache_index_o,
  output logic [1:0]        cache_offset_o,
  output logic              cache_we_o,
  output logic              cache_miss_o,
  output logic              cache_ready_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ready_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int TAG_W = ADDR_W - 7;
  localparam int LINES = 32;

  typedef enum logic [1:0] {
    IDLE,
    MEM_RD,
    REFILL,
    MEM_WR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q [LINES];
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

  logic [ADDR_W-1:0]   sel_addr;
  logic [TAG_W-1:0]    sel_tag;
  logic [4:0]          sel_index;
  logic [1:0]          sel_offset;
  logic                hit;

  logic                stall;
  logic                we;
  logic                miss;
  logic                ready;
  logic                mem_rd;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [31:0]         mem_wdata;
  logic                fill;
  logic                hit_inc;
  logic                miss_inc;

  // In IDLE the lookup uses the live CPU address so read hits complete in the same cycle.
  assign sel_addr   = (state_q == IDLE) ? cpu_addr_i : addr_q;
  assign sel_tag    = sel_addr[ADDR_W-1:7];
  assign sel_index  = sel_addr[6:2];
  assign sel_offset = sel_addr[1:0];
  assign hit        = valid_q[sel_index] && (tag_q[sel_index] == sel_tag);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    stall     = 1'b0;
    we        = 1'b0;
    miss      = 1'b0;
    ready     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill      = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A simultaneous read and write request is resolved as a write.
        if (cpu_wr_i) begin
          stall   = 1'b1;
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          state_d = MEM_WR;
        end else if (cpu_rd_i) begin
          if (hit) begin
            hit_inc = 1'b1;
          end else begin
            stall   = 1'b1;
            addr_d  = cpu_addr_i;
            wdata_d = cpu_wdata_i;
            state_d = MEM_RD;
          end
        end
      end

      MEM_RD: begin
        mem_rd   = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        stall    = 1'b1;
        if (mem_ready_i) begin
          state_d = REFILL;
        end
      end

      REFILL: begin
        miss     = 1'b1;
        ready    = 1'b1;
        fill     = 1'b1;
        miss_inc = 1'b1;
        state_d  = IDLE;
      end

      MEM_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        stall     = 1'b1;
        // No-write-allocate: only a write hit touches the data array.
        if (mem_ready_i) begin
          stall    = 1'b0;
          we       = hit;
          hit_inc  = hit;
          miss_inc = ~hit;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
      end
    end else if (fill) begin
      valid_q[sel_index] <= 1'b1;
      tag_q[sel_index]   <= sel_tag;
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      if (miss_inc && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs are forced low while reset is held so a pending request drops immediately.
  assign cpu_stall_o    = rst_ni & stall;
  assign cache_index_o  = rst_ni ? sel_index : '0;
  assign cache_offset_o = rst_ni ? sel_offset : '0;
  assign cache_we_o     = rst_ni & we;
  assign cache_miss_o   = rst_ni & miss;
  assign cache_ready_o  = rst_ni & ready;
  assign mem_rd_o       = rst_ni & mem_rd;
  assign mem_wr_o       = rst_ni & mem_wr;
  assign mem_addr_o     = rst_ni ? mem_addr : '0;
  assign mem_wdata_o    = rst_ni ? mem_wdata : '0;
  assign hit_cnt_o      = hit_cnt_q;
  assign miss_cnt_o     = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_wt.sv
// Testbench for cache_ctrl_wt: directed scenarios plus randomized traffic checked every cycle
// against a line-level model of the tag/valid array and saturating statistics counters.
module tb_cache_ctrl_wt;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic              cpuRd = 1'b0;
  logic              cpuWr = 1'b0;
  logic [ADDR_W-1:0] cpuAddr = '0;
  logic [31:0]       cpuWdata = '0;
  logic              memReady = 1'b0;
  logic              cpuStall;
  logic [4:0]        cacheIndex;
  logic [1:0]        cacheOffset;
  logic              cacheWe;
  logic              cacheMiss;
  logic              cacheReady;
  logic              memRd;
  logic              memWr;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic [CNT_W-1:0]  hitCnt;
  logic [CNT_W-1:0]  missCnt;

  always #5 clk = ~clk;

  // Narrow counters keep saturation reachable within a short run.
  cache_ctrl_wt #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .cpu_rd_i(cpuRd),
    .cpu_wr_i(cpuWr),
    .cpu_addr_i(cpuAddr),
    .cpu_wdata_i(cpuWdata),
    .cpu_stall_o(cpuStall),
    .cache_index_o(cacheIndex),
    .cache_offset_o(cacheOffset),
    .cache_we_o(cacheWe),
    .cache_miss_o(cacheMiss),
    .cache_ready_o(cacheReady),
    .mem_rd_o(memRd),
    .mem_wr_o(memWr),
    .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata),
    .mem_ready_i(memReady),
    .hit_cnt_o(hitCnt),
    .miss_cnt_o(missCnt)
  );

  int checks = 0;
  int failures = 0;
  bit compareEn = 1'b0;

  bit         mValid [32];
  logic [2:0] mTag   [32];
  int         mHit = 0;
  int         mMiss = 0;

  logic              eStall, eWe, eMiss, eReady, eMemRd, eMemWr;
  logic [4:0]        eIndex;
  logic [1:0]        eOffset;
  logic [ADDR_W-1:0] eMemAddr;
  logic [31:0]       eMemWdata;

  logic [ADDR_W-1:0] lastMemAddr;
  logic              lastWe;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, mid-period, all outputs are held against the model's expectation.
  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("cpu_stall", 32'(cpuStall), 32'(eStall));
      checkOutput("cache_index", 32'(cacheIndex), 32'(eIndex));
      checkOutput("cache_offset", 32'(cacheOffset), 32'(eOffset));
      checkOutput("cache_we", 32'(cacheWe), 32'(eWe));
      checkOutput("cache_miss", 32'(cacheMiss), 32'(eMiss));
      checkOutput("cache_ready", 32'(cacheReady), 32'(eReady));
      checkOutput("mem_rd", 32'(memRd), 32'(eMemRd));
      checkOutput("mem_wr", 32'(memWr), 32'(eMemWr));
      checkOutput("mem_addr", 32'(memAddr), 32'(eMemAddr));
      checkOutput("mem_wdata", memWdata, eMemWdata);
      checkOutput("hit_cnt", 32'(hitCnt), 32'(mHit));
      checkOutput("miss_cnt", 32'(missCnt), 32'(mMiss));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setExpIdle(input logic [ADDR_W-1:0] a);
    eStall    = 1'b0;
    eIndex    = a[6:2];
    eOffset   = a[1:0];
    eWe       = 1'b0;
    eMiss     = 1'b0;
    eReady    = 1'b0;
    eMemRd    = 1'b0;
    eMemWr    = 1'b0;
    eMemAddr  = '0;
    eMemWdata = '0;
  endtask

  function automatic bit modelHit(input logic [ADDR_W-1:0] a);
    return mValid[a[6:2]] && (mTag[a[6:2]] == a[9:7]);
  endfunction

  function automatic int satInc(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic logic [ADDR_W-1:0] randAddr();
    logic [2:0] t;
    logic [4:0] i;
    logic [1:0] o;
    t = 3'($urandom_range(0, 2));
    i = 5'($urandom_range(0, 7));
    o = 2'($urandom_range(0, 3));
    return {t, i, o};
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < 32; i++) begin
      mValid[i] = 1'b0;
      mTag[i]   = '0;
    end
    mHit  = 0;
    mMiss = 0;
  endfunction

  task automatic doRead(input logic [ADDR_W-1:0] a, input int lat);
    bit h;
    h        = modelHit(a);
    cpuRd    = 1'b1;
    cpuWr    = 1'b0;
    cpuAddr  = a;
    cpuWdata = $urandom;
    memReady = 1'($urandom_range(0, 1));
    setExpIdle(a);
    eStall = !h;
    tick();
    if (h) begin
      mHit = satInc(mHit);
      return;
    end
    for (int k = 1; k <= lat; k++) begin
      memReady = (k == lat);
      eMemRd   = 1'b1;
      eMemAddr = {a[9:2], 2'b00};
      eStall   = 1'b1;
      if (k == 1) lastMemAddr = memAddr;
      tick();
    end
    memReady = 1'($urandom_range(0, 1));
    eMemRd   = 1'b0;
    eMemAddr = '0;
    eStall   = 1'b0;
    eMiss    = 1'b1;
    eReady   = 1'b1;
    tick();
    mValid[a[6:2]] = 1'b1;
    mTag[a[6:2]]   = a[9:7];
    mMiss          = satInc(mMiss);
  endtask

  task automatic doWrite(input logic [ADDR_W-1:0] a, input logic [31:0] d, input int lat);
    bit h;
    cpuWr    = 1'b1;
    cpuRd    = 1'($urandom_range(0, 1));
    cpuAddr  = a;
    cpuWdata = d;
    memReady = 1'($urandom_range(0, 1));
    setExpIdle(a);
    eStall = 1'b1;
    tick();
    h = modelHit(a);
    for (int k = 1; k <= lat; k++) begin
      memReady  = (k == lat);
      eMemWr    = 1'b1;
      eMemAddr  = a;
      eMemWdata = d;
      eStall    = (k != lat);
      eWe       = (k == lat) && h;
      if (k == lat) begin
        #1;
        lastWe = cacheWe;
      end
      tick();
    end
    memReady = 1'b0;
    if (h) mHit = satInc(mHit);
    else   mMiss = satInc(mMiss);
  endtask

  task automatic doIdle(input int n);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < n; k++) begin
      a        = randAddr();
      cpuRd    = 1'b0;
      cpuWr    = 1'b0;
      cpuAddr  = a;
      memReady = 1'($urandom_range(0, 1));
      setExpIdle(a);
      tick();
    end
  endtask

  task automatic applyStimulus(input int kind, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                               input int lat);
    case (kind)
      0:       doIdle(lat);
      1:       doRead(a, lat);
      default: doWrite(a, d, lat);
    endcase
  endtask

  initial begin
    clearModel();
    cpuRd   = 1'b1;
    cpuAddr = 10'h3FF;
    #2;
    checkOutput("reset_stall", 32'(cpuStall), 32'd0);
    checkOutput("reset_index", 32'(cacheIndex), 32'd0);
    checkOutput("reset_mem_rd", 32'(memRd), 32'd0);
    checkOutput("reset_miss_cnt", 32'(missCnt), 32'd0);
    tick();
    tick();
    rstN  = 1'b1;
    cpuRd = 1'b0;
    setExpIdle(cpuAddr);
    compareEn = 1'b1;
    doIdle(2);

    // Cold miss, then hit on another word of the refilled line.
    applyStimulus(1, 10'h025, 32'h0, 3);
    checkOutput("t1_mem_addr", 32'(lastMemAddr), 32'h024);
    checkOutput("t1_miss_cnt", 32'(missCnt), 32'd1);
    applyStimulus(1, 10'h027, 32'h0, 1);
    checkOutput("t1_hit_cnt", 32'(hitCnt), 32'd1);

    applyStimulus(2, 10'h026, 32'hDEADBEEF, 2);
    checkOutput("t2_we", 32'(lastWe), 32'd1);
    applyStimulus(1, 10'h026, 32'h0, 1);
    checkOutput("t2_hit_cnt", 32'(hitCnt), 32'd3);

    applyStimulus(2, 10'h3E0, 32'h12345678, 1);
    checkOutput("t3_we", 32'(lastWe), 32'd0);
    applyStimulus(1, 10'h3E0, 32'h0, 2);
    checkOutput("t3_miss_cnt", 32'(missCnt), 32'd3);

    applyStimulus(1, 10'h024, 32'h0, 1);
    applyStimulus(1, 10'h0A4, 32'h0, 2);
    applyStimulus(1, 10'h024, 32'h0, 1);
    checkOutput("t4_hit_cnt", 32'(hitCnt), 32'd4);
    checkOutput("t4_miss_cnt", 32'(missCnt), 32'd5);
    doIdle(1);

    // Reset asserted while a refill request is outstanding.
    cpuRd   = 1'b1;
    cpuWr   = 1'b0;
    cpuAddr = 10'h1A4;
    setExpIdle(cpuAddr);
    eStall = 1'b1;
    tick();
    eMemRd   = 1'b1;
    eMemAddr = 10'h1A4;
    memReady = 1'b0;
    #2;
    checkOutput("t5_pre_mem_rd", 32'(memRd), 32'd1);
    compareEn = 1'b0;
    rstN      = 1'b0;
    #1;
    checkOutput("t5_rst_mem_rd", 32'(memRd), 32'd0);
    checkOutput("t5_rst_stall", 32'(cpuStall), 32'd0);
    clearModel();
    cpuRd   = 1'b0;
    cpuAddr = '0;
    setExpIdle(cpuAddr);
    compareEn = 1'b1;
    tick();
    rstN = 1'b1;
    doIdle(1);
    applyStimulus(1, 10'h024, 32'h0, 1);
    checkOutput("t5_miss_cnt", 32'(missCnt), 32'd1);

    for (int n = 0; n < 900; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      applyStimulus(0, '0, 32'h0, $urandom_range(1, 2));
      else if (r < 7)  applyStimulus(1, randAddr(), 32'h0, $urandom_range(1, 4));
      else             applyStimulus(2, randAddr(), $urandom, $urandom_range(1, 4));
    end

    // Drive the miss counter into saturation and beyond.
    for (int i = 0; i < 600 && mMiss < MAXC; i++) begin
      applyStimulus(1, {3'(3 + (i % 2)), 5'd20, 2'd1}, 32'h0, 1);
    end
    applyStimulus(1, 10'h3D0, 32'h0, 1);
    applyStimulus(1, 10'h250, 32'h0, 1);
    checkOutput("t6_miss_sat", 32'(missCnt), 32'hFF);

    doIdle(2);
    compareEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
